// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle instruction sequencer: state encoding,
// decoder OP codes and the latched per-instruction request bundle.
package cpu_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd7
  } state_t;

  typedef enum logic [OP_W-1:0] {
    OP_DP  = 2'd0,
    OP_MEM = 2'd1,
    OP_BR  = 2'd2,
    OP_NOP = 2'd3
  } op_t;

  typedef struct packed {
    logic reg_write;
    logic flag_write;
    logic mem_write;
    logic load;
    logic branch;
  } req_t;

  // Wait counter must hold 0..timeout; a disabled timeout still needs one bit.
  function automatic int unsigned wait_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_timeout.sv
// Counts consecutive not-ready cycles and flags the last allowed one so the
// sequencer can divert to FAULT when ready still has not arrived.
module bus_timeout
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic at_limit
);

  localparam int unsigned W     = wait_width(TIMEOUT);
  localparam int unsigned LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wait_cnt <= '0;
    end else if (count) begin
      wait_cnt <= wait_cnt + W'(1);
    end
  end

  // A zero TIMEOUT never expires; the counter then simply wraps unused.
  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign at_limit = 1'b0;
    end else begin : g_enabled
      assign at_limit = (wait_cnt == W'(LIMIT));
    end
  endgenerate

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback, with
// memory wait states, fetch stall, bus-timeout fault and a retire counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [OP_W-1:0]  op_in,
  input  logic             reg_write_req,
  input  logic             flag_write_req,
  input  logic             mem_write_req,
  input  logic             load_req,
  input  logic             branch_req,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_write_en,
  output logic             pc_sel,
  output logic             rf_write_en,
  output logic             flag_write_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             fault,
  output logic [STATE_W-1:0] state_out,
  output logic [CNT_W-1:0] retired_count
);

  state_t           state;
  state_t           state_next;
  op_t              op_q;
  req_t             req_q;
  logic [CNT_W-1:0] retired_q;
  logic             wait_count;
  logic             wait_clear;
  logic             at_limit;
  logic             retire;

  bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (wait_clear),
    .count    (wait_count),
    .at_limit (at_limit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next state; ready always beats an expiring timeout on the same cycle.
  always_comb begin
    state_next = state;
    wait_count = 1'b0;
    case (state)
      S_FETCH: begin
        if (!stall) begin
          if (imem_ready) begin
            state_next = S_DECODE;
          end else if (at_limit) begin
            state_next = S_FAULT;
          end else begin
            wait_count = 1'b1;
          end
        end
      end
      S_DECODE: begin
        state_next = (op_t'(op_in) == OP_NOP) ? S_FETCH : S_EXECUTE;
      end
      S_EXECUTE: begin
        state_next = (op_q == OP_MEM) ? S_MEMORY : S_FETCH;
      end
      S_MEMORY: begin
        if (dmem_ready) begin
          state_next = req_q.load ? S_WRITEBACK : S_FETCH;
        end else if (at_limit) begin
          state_next = S_FAULT;
        end else begin
          wait_count = 1'b1;
        end
      end
      S_WRITEBACK: state_next = S_FETCH;
      S_FAULT:     state_next = S_FAULT;
      default:     state_next = S_FETCH;
    endcase
    wait_clear = (state_next != state) || ((state == S_FETCH) && stall);
  end

  // Mealy output decode, forced to zero while reset is asserted.
  always_comb begin
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    pc_write_en   = 1'b0;
    pc_sel        = 1'b0;
    rf_write_en   = 1'b0;
    flag_write_en = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    fault         = 1'b0;
    retire        = 1'b0;
    state_out     = '0;
    retired_count = '0;
    if (!rst) begin
      state_out     = state;
      retired_count = retired_q;
      case (state)
        S_FETCH: begin
          imem_req = !stall;
          ir_load  = !stall && imem_ready;
        end
        S_DECODE: begin
          if (op_t'(op_in) == OP_NOP) begin
            pc_write_en = 1'b1;
            retire      = 1'b1;
          end
        end
        S_EXECUTE: begin
          case (op_q)
            OP_DP: begin
              rf_write_en   = req_q.reg_write;
              flag_write_en = req_q.flag_write;
              pc_write_en   = 1'b1;
              retire        = 1'b1;
            end
            OP_BR: begin
              pc_write_en = 1'b1;
              pc_sel      = req_q.branch;
              retire      = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEMORY: begin
          dmem_req = 1'b1;
          dmem_we  = req_q.mem_write;
          if (dmem_ready && !req_q.load) begin
            pc_write_en = 1'b1;
            retire      = 1'b1;
          end
        end
        S_WRITEBACK: begin
          rf_write_en = 1'b1;
          pc_write_en = 1'b1;
          retire      = 1'b1;
        end
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

  // Decoder requests are captured once per instruction, in DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_DP;
      req_q <= '0;
    end else if (state == S_DECODE) begin
      op_q  <= op_t'(op_in);
      req_q <= '{reg_write:  reg_write_req,
                 flag_write: flag_write_req,
                 mem_write:  mem_write_req,
                 load:       load_req,
                 branch:     branch_req};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed plus randomized instruction streams checked cycle by cycle
// against a per-instruction trace model of the sequencer.
module tb_cpu_sequencer;

  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 8;

  localparam logic [7:0] B_IMEM = 8'h80;
  localparam logic [7:0] B_IR   = 8'h40;
  localparam logic [7:0] B_PCW  = 8'h20;
  localparam logic [7:0] B_SEL  = 8'h10;
  localparam logic [7:0] B_RF   = 8'h08;
  localparam logic [7:0] B_FL   = 8'h04;
  localparam logic [7:0] B_DR   = 8'h02;
  localparam logic [7:0] B_DW   = 8'h01;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic [1:0]    op_in = 2'd0;
  logic          reg_write_req = 1'b0;
  logic          flag_write_req = 1'b0;
  logic          mem_write_req = 1'b0;
  logic          load_req = 1'b0;
  logic          branch_req = 1'b0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          imem_req, ir_load, pc_write_en, pc_sel, rf_write_en;
  logic          flag_write_en, dmem_req, dmem_we, fault;
  logic [2:0]    state_out;
  logic [CW-1:0] retired_count;

  int            vectors = 0;
  int            miscompares = 0;
  logic [CW-1:0] model_cnt = '0;

  cpu_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .op_in          (op_in),
    .reg_write_req  (reg_write_req),
    .flag_write_req (flag_write_req),
    .mem_write_req  (mem_write_req),
    .load_req       (load_req),
    .branch_req     (branch_req),
    .imem_ready     (imem_ready),
    .dmem_ready     (dmem_ready),
    .imem_req       (imem_req),
    .ir_load        (ir_load),
    .pc_write_en    (pc_write_en),
    .pc_sel         (pc_sel),
    .rf_write_en    (rf_write_en),
    .flag_write_en  (flag_write_en),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .fault          (fault),
    .state_out      (state_out),
    .retired_count  (retired_count)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] rop();
    return 2'($urandom_range(0, 3));
  endfunction

  function automatic logic [4:0] rrq();
    return 5'($urandom);
  endfunction

  // Expected vector: {fault, state, imem, ir, pcw, sel, rf, flag, dreq, dwe}
  function automatic logic [11:0] ev(input logic [2:0] st, input logic [7:0] bits,
                                     input logic flt);
    return {flt, st, bits};
  endfunction

  // One clock: drive inputs after the edge, check mid-cycle, advance model.
  task automatic cyc(input logic r, input logic s, input logic ir_v, input logic dr_v,
                     input logic [1:0] op, input logic [4:0] rq,
                     input logic [11:0] exp, input logic ret);
    logic [11:0]   obs;
    logic [CW-1:0] exp_cnt;
    @(posedge clk);
    #1;
    rst = r; stall = s; imem_ready = ir_v; dmem_ready = dr_v; op_in = op;
    {reg_write_req, flag_write_req, mem_write_req, load_req, branch_req} = rq;
    #3;
    obs = {fault, state_out, imem_req, ir_load, pc_write_en, pc_sel,
           rf_write_en, flag_write_en, dmem_req, dmem_we};
    exp_cnt = r ? '0 : model_cnt;
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL outputs t=%0t observed=%h expected=%h", $time, obs, exp);
    end
    vectors++;
    assert (retired_count === exp_cnt) else begin
      miscompares++;
      $error("FAIL retired_count t=%0t observed=%0d expected=%0d", $time, retired_count, exp_cnt);
    end
    if (r) model_cnt = '0;
    else if (ret) model_cnt = model_cnt + CW'(1);
  endtask

  // Fetch with k wait cycles and decode; returns after DECODE.
  task automatic fetch_decode(input logic [1:0] op, input logic [4:0] rq, input int k);
    for (int i = 0; i < k; i++)
      cyc(1'b0, 1'b0, 1'b0, rb(), rop(), rrq(), ev(3'd0, B_IMEM, 1'b0), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, rb(), rop(), rrq(), ev(3'd0, B_IMEM | B_IR, 1'b0), 1'b0);
    cyc(1'b0, rb(), rb(), rb(), op, rq,
        ev(3'd1, (op == 2'd3) ? B_PCW : 8'h00, 1'b0), op == 2'd3);
  endtask

  // Whole instruction: k fetch waits, m data-memory waits (m < TO).
  task automatic instr(input logic [1:0] op, input logic [4:0] rq, input int k, input int m);
    logic rw, fw, mw, ld, br;
    {rw, fw, mw, ld, br} = rq;
    fetch_decode(op, rq, k);
    case (op)
      2'd0: cyc(1'b0, rb(), rb(), rb(), rop(), rrq(),
                ev(3'd2, B_PCW | (rw ? B_RF : 8'h00) | (fw ? B_FL : 8'h00), 1'b0), 1'b1);
      2'd2: cyc(1'b0, rb(), rb(), rb(), rop(), rrq(),
                ev(3'd2, B_PCW | (br ? B_SEL : 8'h00), 1'b0), 1'b1);
      2'd1: begin
        cyc(1'b0, rb(), rb(), rb(), rop(), rrq(), ev(3'd2, 8'h00, 1'b0), 1'b0);
        for (int j = 0; j < m; j++)
          cyc(1'b0, rb(), rb(), 1'b0, rop(), rrq(),
              ev(3'd3, B_DR | (mw ? B_DW : 8'h00), 1'b0), 1'b0);
        cyc(1'b0, rb(), rb(), 1'b1, rop(), rrq(),
            ev(3'd3, B_DR | (mw ? B_DW : 8'h00) | (ld ? 8'h00 : B_PCW), 1'b0), !ld);
        if (ld)
          cyc(1'b0, rb(), rb(), rb(), rop(), rrq(), ev(3'd4, B_RF | B_PCW, 1'b0), 1'b1);
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    cyc(1'b1, rb(), rb(), rb(), rop(), rrq(), 12'h000, 1'b0);
  endtask

  initial begin
    do_reset();
    do_reset();

    instr(2'd0, 5'b11000, 0, 0);        // data-proc with reg+flag write
    instr(2'd1, 5'b00010, 0, 2);        // LDR, two wait states
    instr(2'd1, 5'b00100, 0, 0);        // STR, immediate ready
    instr(2'd3, 5'b11111, 0, 0);        // cond-fail
    instr(2'd2, 5'b00001, 1, 0);        // taken branch
    instr(2'd1, 5'b00010, 3, 3);        // ready on the last allowed cycle

    for (int i = 0; i < 5; i++)          // stall holds FETCH, no request
      cyc(1'b0, 1'b1, rb(), rb(), rop(), rrq(), ev(3'd0, 8'h00, 1'b0), 1'b0);
    instr(2'd0, 5'b10000, 0, 0);

    // Reset in MEMORY abandons the load
    fetch_decode(2'd1, 5'b00010, 0);
    cyc(1'b0, rb(), rb(), rb(), rop(), rrq(), ev(3'd2, 8'h00, 1'b0), 1'b0);
    cyc(1'b0, rb(), rb(), 1'b0, rop(), rrq(), ev(3'd3, B_DR, 1'b0), 1'b0);
    do_reset();
    instr(2'd2, 5'b00000, 0, 0);

    for (int n = 0; n < 300; n++)
      instr(rop(), rrq(), int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)));

    // Data-memory timeout into sticky FAULT
    fetch_decode(2'd1, 5'b00100, 0);
    cyc(1'b0, rb(), rb(), rb(), rop(), rrq(), ev(3'd2, 8'h00, 1'b0), 1'b0);
    for (int j = 0; j < TO; j++)
      cyc(1'b0, rb(), rb(), 1'b0, rop(), rrq(), ev(3'd3, B_DR | B_DW, 1'b0), 1'b0);
    for (int j = 0; j < 6; j++)
      cyc(1'b0, rb(), rb(), rb(), rop(), rrq(), ev(3'd7, 8'h00, 1'b1), 1'b0);
    do_reset();

    // Instruction-fetch timeout
    for (int j = 0; j < TO; j++)
      cyc(1'b0, 1'b0, 1'b0, rb(), rop(), rrq(), ev(3'd0, B_IMEM, 1'b0), 1'b0);
    cyc(1'b0, rb(), rb(), rb(), rop(), rrq(), ev(3'd7, 8'h00, 1'b1), 1'b0);
    do_reset();
    instr(2'd0, 5'b01000, 1, 0);
    cyc(1'b0, 1'b1, rb(), rb(), rop(), rrq(), ev(3'd0, 8'h00, 1'b0), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM sequencing one instruction at a time: fetch, decode, execute, memory, writeback.
- Sits between the instruction decoder and the PC, instruction register, register file, flag register and data memory.
- Latches the decoder's per-instruction requests in DECODE and turns them into single-cycle write strobes.
- Handles memory wait states, a stall/halt input and a bus-timeout fault.

Parameters:
- TIMEOUT, 16: max wait cycles for imem_ready/dmem_ready before fault; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold in FETCH; no fetch is issued
- op_in  in  2  decoder OP: 0 data-proc, 1 memory, 2 branch, 3 cond-fail/undefined
- reg_write_req  in  1  decoder register-file write enable
- flag_write_req  in  1  decoder flag-register write enable
- mem_write_req  in  1  decoder memory write (STR)
- load_req  in  1  decoder LDR indication (register-file mux selects memory)
- branch_req  in  1  decoder branch-taken select
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_load  out  1  load instruction register
- pc_write_en  out  1  update PC
- pc_sel  out  1  0 = PC+4, 1 = branch target
- rf_write_en  out  1  register-file write strobe
- flag_write_en  out  1  flag-register write strobe
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write
- fault  out  1  bus timeout occurred, sticky
- state_out  out  3  current state (debug)
- retired_count  out  CNT_W  completed instructions, wraps

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset state: rst high at a clock edge -> state=FETCH, wait_cnt=0, retired_count=0, latched requests=0, fault=0.
- Outputs during reset: while rst is high, every output is forced to 0, combinationally gated.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, FAULT=7.
- Output style: outputs are Mealy decodes of state plus the latched requests; all strobes last 1 cycle.
- FETCH, stall=1: imem_req=0, state held, wait_cnt held at 0.
- FETCH, stall=0: imem_req=1.
  - imem_ready=1: ir_load=1, go to DECODE.
  - Otherwise: wait_cnt++.
- DECODE: lasts 1 cycle; latches op_in and all five *_req inputs into op_q/req_q.
  - op_in=3: pc_write_en=1, pc_sel=0, retire, go to FETCH; no other strobes.
  - Else: go to EXECUTE.
- EXECUTE, op_q=0: rf_write_en=reg_write_q, flag_write_en=flag_write_q, pc_write_en=1, pc_sel=0, retire, go to FETCH.
- EXECUTE, op_q=2: pc_write_en=1, pc_sel=branch_q, retire, go to FETCH.
- EXECUTE, op_q=1: no strobes, go to MEMORY, wait_cnt=0.
- MEMORY: dmem_req=1, dmem_we=mem_write_q, held stable until dmem_ready.
  - dmem_ready with load_q=1: go to WRITEBACK.
  - dmem_ready with load_q=0: pc_write_en=1, retire, go to FETCH.
  - Otherwise: wait_cnt++.
- WRITEBACK: rf_write_en=1, pc_write_en=1, pc_sel=0, retire, go to FETCH.
- Timeout: in FETCH(stall=0) or MEMORY, if TIMEOUT≠0 and wait_cnt==TIMEOUT-1 and ready=0 -> go to FAULT.
  - This means TIMEOUT consecutive not-ready cycles.
  - If ready is asserted on that same cycle, ready wins.
- FAULT: all strobes and requests 0, fault=1; only rst exits.
- wait_cnt: cleared on every state change; width is clog2(TIMEOUT+1), minimum 1.
- Retire: retired_count++ (mod 2^CNT_W) on each retire event, including cond-fail.
- stall: ignored outside FETCH; an instruction in flight always completes.
- rst mid-operation: abandons the instruction with no strobes, including in MEMORY, WRITEBACK and FAULT.
- Mutual exclusion: ir_load, dmem_req and rf_write_en never assert in the same cycle as each other.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding constants;
  - OP codes (OP_DP=0, OP_MEM=1, OP_BR=2, OP_NOP=3).
- Sub-module bus_timeout: wait counter plus the expire comparator, parameterised by TIMEOUT, instantiated once.

Test Plan:
- Data-proc, op=0, reg_write_req=1, flag_write_req=1, imem_ready=1 -> states 0,1,2.
  - Cycle 3: rf_write_en=flag_write_en=pc_write_en=1, pc_sel=0.
  - retired_count=1.
- LDR, op=1, load_req=1, dmem_ready after 2 low cycles -> MEMORY for 3 cycles with dmem_req=1, dmem_we=0.
  - WRITEBACK: rf_write_en=1, pc_write_en=1.
  - 7 cycles total.
- STR, op=1, mem_write_req=1, dmem_ready immediate -> dmem_we=1 for 1 cycle, rf_write_en never 1, retire.
- Cond-fail op=3, then branch op=2 with branch_req=1:
  - Cond-fail: DECODE gives pc_write_en=1, pc_sel=0 only.
  - Branch: EXECUTE gives pc_sel=1.
  - retired_count=+2.
- TIMEOUT=4, dmem_ready held 0 -> after 4 MEMORY cycles state_out=7, fault=1, held.
  - dmem_ready=1 on the 4th cycle instead -> normal completion.
- stall=1 for 5 cycles in FETCH -> imem_req=0 throughout, no timeout.
  - rst asserted in MEMORY -> next cycle FETCH, no strobes, retired_count=0.
